// File: rtl/chiplet_types_pkg.sv
// Shared link types: flit layout and the VC index field width.
package chiplet_types_pkg;

    localparam int unsigned VC_IDX_W  = 2;
    localparam int unsigned PAYLOAD_W = 32;

    typedef logic [VC_IDX_W-1:0] vc_idx_t;

    typedef struct packed {
        vc_idx_t              vc;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

endpackage

// File: rtl/vc_rx_buffer_if.sv
// Link-side and consumer-side signals of the VC receive buffer.
interface vc_rx_buffer_if #(
    parameter int unsigned NUM_VCS = 2
);
    import chiplet_types_pkg::*;

    localparam int unsigned OUT_VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

    flit_t               in;
    logic                data_ready_in;
    flit_t               out;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_VC_W-1:0] out_vc;
    logic [NUM_VCS-1:0]  credit_granted;
    logic [NUM_VCS-1:0]  buffer_available;
    logic                overflow_err;

    modport master (
        output in, data_ready_in, out_ready,
        input  out, out_valid, out_vc, credit_granted, buffer_available, overflow_err
    );

    modport slave (
        input  in, data_ready_in, out_ready,
        output out, out_valid, out_vc, credit_granted, buffer_available, overflow_err
    );

endinterface

// File: rtl/vc_rx_buffer_fifo.sv
// Single-clock flit FIFO for one VC; a push into a full FIFO is accepted only
// when a pop frees the slot in the same cycle.
module vc_fifo
    import chiplet_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  flit_t wr_data,
    output flit_t head,
    output logic  full,
    output logic  full_next_c,
    output logic  empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;
    flit_t            mem [DEPTH];

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign do_pop      = pop && !empty;
    assign do_push     = push && (!full || do_pop);
    assign head        = mem[rd_ptr];
    assign full_next_c = (count_next == CNT_W'(DEPTH));

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/vc_rx_buffer.sv
// Receive end of a switch link: per-VC flit buffering, round-robin delivery
// to the local consumer and one credit return per departed flit.
module vc_rx_buffer
    import chiplet_types_pkg::*;
#(
    parameter int unsigned NUM_VCS      = 2,
    parameter int unsigned BUFFER_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    vc_rx_buffer_if.slave  bus
);

    localparam int unsigned OUT_VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

    logic [NUM_VCS-1:0]  push_vec;
    logic [NUM_VCS-1:0]  pop_vec;
    logic [NUM_VCS-1:0]  full_vec;
    logic [NUM_VCS-1:0]  full_next_vec;
    logic [NUM_VCS-1:0]  empty_vec;
    flit_t               head [NUM_VCS];
    logic [OUT_VC_W-1:0] rr;
    logic [OUT_VC_W-1:0] grant_idx;
    logic [OUT_VC_W-1:0] scan_idx;
    logic                grant_valid;
    logic                handshake;
    logic                vc_oob;
    logic                drop;
    logic [NUM_VCS-1:0]  credit_q;
    logic [NUM_VCS-1:0]  avail_q;
    logic                overflow_q;

    assign handshake = grant_valid && bus.out_ready;

    for (genvar v = 0; v < int'(NUM_VCS); v++) begin : g_vc
        assign push_vec[v] = bus.data_ready_in && (int'(bus.in.vc) == v);
        assign pop_vec[v]  = handshake && (grant_idx == OUT_VC_W'(v));

        vc_fifo #(
            .DEPTH (BUFFER_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push        (push_vec[v]),
            .pop         (pop_vec[v]),
            .wr_data     (bus.in),
            .head        (head[v]),
            .full        (full_vec[v]),
            .full_next_c (full_next_vec[v]),
            .empty       (empty_vec[v])
        );
    end

    assign vc_oob = bus.data_ready_in && (int'(bus.in.vc) >= int'(NUM_VCS));
    assign drop   = vc_oob || (|(push_vec & full_vec & ~pop_vec));

    // Round-robin: first non-empty VC after the last served one.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 1; i <= int'(NUM_VCS); i++) begin
            scan_idx = OUT_VC_W'((32'(rr) + 32'(i)) % NUM_VCS);
            if (!grant_valid && !empty_vec[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr         <= OUT_VC_W'(NUM_VCS - 1);
            credit_q   <= '0;
            avail_q    <= '1;
            overflow_q <= 1'b0;
        end else begin
            if (handshake) rr <= grant_idx;
            credit_q <= pop_vec;
            avail_q  <= ~full_next_vec;
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign bus.out_valid        = grant_valid;
    assign bus.out              = grant_valid ? head[grant_idx] : '0;
    assign bus.out_vc           = grant_valid ? grant_idx : '0;
    assign bus.credit_granted   = credit_q;
    assign bus.buffer_available = avail_q;
    assign bus.overflow_err     = overflow_q;

endmodule

// File: tb/tb_vc_rx_buffer.sv
// Directed scenario bench for vc_rx_buffer (NUM_VCS=2, BUFFER_DEPTH=4).
module tb_vc_rx_buffer;
    import chiplet_types_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vc_rx_buffer_if #(.NUM_VCS(2)) bus ();

    vc_rx_buffer #(
        .NUM_VCS      (2),
        .BUFFER_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic flit_t mk(input logic [1:0] vc, input logic [31:0] d);
        flit_t f;
        f.vc      = vc;
        f.payload = d;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in            = '0;
        bus.data_ready_in = 1'b0;
        bus.out_ready     = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        bus.in = mk(2'd3, 32'h33); bus.data_ready_in = 1'b1; tick();
        bus.in = mk(2'd0, 32'h0A); tick();
        bus.data_ready_in = 1'b0;
        checks++; if (bus.overflow_err !== 1'b1) begin failures++; $display("FAIL rst_pre_overflow got=%b exp=1", bus.overflow_err); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.credit_granted !== 2'b00) begin failures++; $display("FAIL rst_credit got=%b exp=00", bus.credit_granted); end
        checks++; if (bus.buffer_available !== 2'b11) begin failures++; $display("FAIL rst_avail got=%b exp=11", bus.buffer_available); end
        checks++; if (bus.overflow_err !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", bus.overflow_err); end
        checks++; if (bus.out !== flit_t'('0) || bus.out_vc !== 1'b0) begin failures++; $display("FAIL rst_out got=%h/%b exp=0/0", bus.out, bus.out_vc); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        bus.in = mk(2'd0, 32'hA5A5_0001); bus.data_ready_in = 1'b1; bus.out_ready = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_c0_valid got=%b exp=0", bus.out_valid); end
        tick();
        bus.data_ready_in = 1'b0;
        checks++; if ({bus.out_valid, bus.out_vc, bus.out} !== {1'b1, 1'b0, mk(2'd0, 32'hA5A5_0001)})
            begin failures++; $display("FAIL single_c1_out got=%b/%b/%h exp=1/0/%h", bus.out_valid, bus.out_vc, bus.out, mk(2'd0, 32'hA5A5_0001)); end
        checks++; if (bus.credit_granted !== 2'b00) begin failures++; $display("FAIL single_c1_credit got=%b exp=00", bus.credit_granted); end
        tick();
        checks++; if (bus.credit_granted !== 2'b01) begin failures++; $display("FAIL single_c2_credit got=%b exp=01", bus.credit_granted); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_c2_valid got=%b exp=0", bus.out_valid); end
        tick();
        checks++; if (bus.credit_granted !== 2'b00) begin failures++; $display("FAIL single_c3_credit got=%b exp=00", bus.credit_granted); end
        idle_inputs();
    endtask

    task automatic test_fill_overflow();
        int pulses;
        apply_reset();
        bus.data_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in = mk(2'd1, 32'h100 + i);
            tick();
            if (i == 2) begin
                checks++; if (bus.buffer_available !== 2'b11) begin failures++; $display("FAIL fill_avail3 got=%b exp=11", bus.buffer_available); end
            end
        end
        checks++; if (bus.buffer_available !== 2'b01) begin failures++; $display("FAIL fill_avail4 got=%b exp=01", bus.buffer_available); end
        checks++; if (bus.overflow_err !== 1'b0) begin failures++; $display("FAIL fill_no_ovf got=%b exp=0", bus.overflow_err); end
        bus.in = mk(2'd1, 32'h1FF);
        tick();
        bus.data_ready_in = 1'b0;
        checks++; if (bus.overflow_err !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", bus.overflow_err); end
        checks++; if (bus.buffer_available !== 2'b01) begin failures++; $display("FAIL fill_avail5 got=%b exp=01", bus.buffer_available); end
        bus.out_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({bus.out_valid, bus.out_vc, bus.out} !== {1'b1, 1'b1, mk(2'd1, 32'h100 + i)})
                begin failures++; $display("FAIL drain_out%0d got=%b/%b/%h exp=1/1/%h", i, bus.out_valid, bus.out_vc, bus.out, mk(2'd1, 32'h100 + i)); end
            tick();
            if (bus.credit_granted == 2'b10) pulses++;
        end
        checks++; if (pulses !== 4) begin failures++; $display("FAIL drain_pulses got=%0d exp=4", pulses); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", bus.out_valid); end
        checks++; if (bus.buffer_available !== 2'b11) begin failures++; $display("FAIL drain_avail got=%b exp=11", bus.buffer_available); end
        tick();
        checks++; if (bus.credit_granted !== 2'b00) begin failures++; $display("FAIL drain_credit_end got=%b exp=00", bus.credit_granted); end
        checks++; if (bus.overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow_err); end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] vc;
        logic [1:0] prev_oh;
        logic [31:0] d;
        apply_reset();
        bus.data_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in = (i < 3) ? mk(2'd0, 32'hA0 + i) : mk(2'd1, 32'hB0 + i - 3);
            tick();
        end
        bus.data_ready_in = 1'b0;
        bus.out_ready     = 1'b1;
        prev_oh = 2'b00;
        for (int i = 0; i < 6; i++) begin
            vc = 2'(i % 2);
            d  = (vc == 2'd0) ? 32'hA0 + i / 2 : 32'hB0 + i / 2;
            checks++; if ({bus.out_valid, bus.out_vc, bus.out} !== {1'b1, vc[0], mk(vc, d)})
                begin failures++; $display("FAIL rr_out%0d got=%b/%b/%h exp=1/%b/%h", i, bus.out_valid, bus.out_vc, bus.out, vc[0], mk(vc, d)); end
            checks++; if (bus.credit_granted !== prev_oh) begin failures++; $display("FAIL rr_credit%0d got=%b exp=%b", i, bus.credit_granted, prev_oh); end
            prev_oh = (vc == 2'd0) ? 2'b01 : 2'b10;
            tick();
        end
        checks++; if (bus.credit_granted !== 2'b10) begin failures++; $display("FAIL rr_credit_last got=%b exp=10", bus.credit_granted); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rr_empty got=%b exp=0", bus.out_valid); end
        idle_inputs();
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        bus.data_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in = mk(2'd0, 32'hC0 + i);
            tick();
        end
        checks++; if (bus.buffer_available !== 2'b10) begin failures++; $display("FAIL fpp_full got=%b exp=10", bus.buffer_available); end
        bus.in = mk(2'd0, 32'hC4);
        bus.out_ready = 1'b1;
        checks++; if (bus.out !== mk(2'd0, 32'hC0)) begin failures++; $display("FAIL fpp_head got=%h exp=%h", bus.out, mk(2'd0, 32'hC0)); end
        tick();
        bus.data_ready_in = 1'b0;
        checks++; if (bus.overflow_err !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%b exp=0", bus.overflow_err); end
        checks++; if (bus.buffer_available !== 2'b10) begin failures++; $display("FAIL fpp_avail got=%b exp=10", bus.buffer_available); end
        checks++; if (bus.credit_granted !== 2'b01) begin failures++; $display("FAIL fpp_credit got=%b exp=01", bus.credit_granted); end
        for (int i = 1; i < 5; i++) begin
            checks++; if ({bus.out_valid, bus.out} !== {1'b1, mk(2'd0, 32'hC0 + i)})
                begin failures++; $display("FAIL fpp_out%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out, mk(2'd0, 32'hC0 + i)); end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fpp_empty got=%b exp=0", bus.out_valid); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.data_ready_in = 1'b1;
        bus.in = mk(2'd1, 32'hD0); tick();
        bus.in = mk(2'd1, 32'hD1); tick();
        bus.data_ready_in = 1'b0;
        bus.out_ready     = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.out_valid); end
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({bus.credit_granted, bus.out_valid} !== 3'b000)
                begin failures++; $display("FAIL mid_quiet%0d got=%b/%b exp=00/0", i, bus.credit_granted, bus.out_valid); end
            tick();
        end
        bus.in = mk(2'd0, 32'hE0); bus.data_ready_in = 1'b1;
        tick();
        bus.data_ready_in = 1'b0;
        checks++; if ({bus.out_valid, bus.out_vc, bus.out} !== {1'b1, 1'b0, mk(2'd0, 32'hE0)})
            begin failures++; $display("FAIL mid_next got=%b/%b/%h exp=1/0/%h", bus.out_valid, bus.out_vc, bus.out, mk(2'd0, 32'hE0)); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.credit_granted !== 2'b01) begin failures++; $display("FAIL mid_credit got=%b exp=01", bus.credit_granted); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_empty got=%b exp=0", bus.out_valid); end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_fill_overflow();
        test_round_robin();
        test_full_push_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
